// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with the transmitter)
// and default frame geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam int DEFAULT_OVERSAMPLE = 16;
    localparam int DEFAULT_DATA_BITS  = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a
// configurable reset value so idle-high and idle-low lines both reset cleanly.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receive path: oversampled start detect, LSB-first deserialiser,
// byte holding register with sticky ready / framing / overrun status.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int DATA_BITS  = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx,
    input  logic                 i_sample_en,
    input  logic                 i_rd_clr,
    output logic [DATA_BITS-1:0] o_data_out,
    output logic                 o_ready,
    output logic                 o_framing_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 w_rx_s;
    uart_state_e          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] r_data_out;
    logic                 r_ready;
    logic                 r_framing_err;
    logic                 r_overrun;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .i_d (i_rx),
        .o_q (w_rx_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shreg       <= '0;
            r_data_out    <= '0;
            r_ready       <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            // Host clear first; a completion in the same cycle overrides it below.
            if (i_rd_clr) begin
                r_ready       <= 1'b0;
                r_framing_err <= 1'b0;
                r_overrun     <= 1'b0;
            end
            if (i_sample_en) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_rx_s) begin
                            r_state <= ST_START;
                            r_cnt   <= '0;
                        end
                    end
                    ST_START: begin
                        if (r_cnt == CNT_HALF) begin
                            r_cnt <= '0;
                            r_idx <= '0;
                            r_state <= w_rx_s ? ST_IDLE : ST_DATA;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (r_cnt == CNT_LAST) begin
                            r_shreg[r_idx] <= w_rx_s;
                            r_cnt          <= '0;
                            if (r_idx == IDX_LAST) begin
                                r_state <= ST_STOP;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (r_cnt == CNT_LAST) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            if (w_rx_s) begin
                                r_data_out <= r_shreg;
                                r_ready    <= 1'b1;
                                if (r_ready && !i_rd_clr) begin
                                    r_overrun <= 1'b1;
                                end
                            end else begin
                                r_framing_err <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_data_out    = r_data_out;
    assign o_ready       = r_ready;
    assign o_framing_err = r_framing_err;
    assign o_overrun     = r_overrun;
    assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Randomised scoreboard bench for uart_receiver: stimulus pushes the expected
// status per frame, a monitor checks it when busy falls at the end of each frame.
module tb_uart_receiver;

    logic       clk;
    logic       rst;
    logic       rx;
    logic       sample_en;
    logic       rd_clr;
    logic [7:0] data_out;
    logic       ready;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       ready;
        logic       fe;
        logic       ovr;
    } exp_t;

    exp_t exp_q[$];

    // Frame-level reference model of the status registers.
    logic [7:0] m_data;
    logic       m_ready;
    logic       m_fe;
    logic       m_ovr;

    uart_receiver dut (
        .clk           (clk),
        .rst           (rst),
        .i_rx          (rx),
        .i_sample_en   (sample_en),
        .i_rd_clr      (rd_clr),
        .o_data_out    (data_out),
        .o_ready       (ready),
        .o_framing_err (framing_err),
        .o_overrun     (overrun),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_data_out"}, 32'(data_out), 32'(m_data));
        chk({tag, "_ready"}, 32'(ready), 32'(m_ready));
        chk({tag, "_framing_err"}, 32'(framing_err), 32'(m_fe));
        chk({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // One oversample period: rx settles for gap clocks, then a one-cycle tick.
    task automatic period(input logic b, input logic clr_on_tick, input int gap);
        rx        = b;
        sample_en = 1'b0;
        rd_clr    = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        sample_en = 1'b1;
        rd_clr    = clr_on_tick;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        rd_clr    = 1'b0;
    endtask

    task automatic model_clear();
        m_ready = 1'b0;
        m_fe    = 1'b0;
        m_ovr   = 1'b0;
    endtask

    // A frame is 160 ticks: start 0-15, data 16-143, stop 144-159, mid-stop at 152.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic coin_clr);
        logic b;
        if (stop) begin
            m_ovr   = coin_clr ? 1'b0 : (m_ovr | m_ready);
            m_ready = 1'b1;
            m_data  = d;
            if (coin_clr) m_fe = 1'b0;
        end else begin
            m_fe = 1'b1;
            if (coin_clr) begin
                m_ready = 1'b0;
                m_ovr   = 1'b0;
            end
        end
        exp_q.push_back('{data: m_data, ready: m_ready, fe: m_fe, ovr: m_ovr});
        for (int p = 0; p < 160; p++) begin
            if (p < 16)       b = 1'b0;
            else if (p < 144) b = d[(p - 16) / 16];
            else if (p <= 152) b = stop;
            else              b = 1'b1;
            period(b, coin_clr && (p == 152), int'($urandom_range(2, 4)));
        end
    endtask

    task automatic send_glitch();
        exp_q.push_back('{data: m_data, ready: m_ready, fe: m_fe, ovr: m_ovr});
        for (int p = 0; p < 16; p++) begin
            period(p >= 5, 1'b0, int'($urandom_range(2, 4)));
        end
    endtask

    task automatic idle(input int n, input logic clr);
        for (int p = 0; p < n; p++) begin
            period(1'b1, clr && (p == 0), int'($urandom_range(2, 4)));
        end
        if (clr && n > 0) model_clear();
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        rx        = 1'b1;
        sample_en = 1'b0;
        rd_clr    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        m_data = 8'h00;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: a busy falling edge marks the end of a frame or a rejected glitch.
    initial begin
        logic prev_busy;
        exp_t e;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 1'b0;
            end else begin
                if (prev_busy && !busy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_txn actual=busy_fall required=no_event");
                    end else begin
                        e = exp_q.pop_front();
                        txn++;
                        $display("txn %0d: data_out=%02h ready=%0b framing_err=%0b overrun=%0b (exp %02h %0b %0b %0b)",
                                 txn, data_out, ready, framing_err, overrun, e.data, e.ready, e.fe, e.ovr);
                        chk("txn_data_out", 32'(data_out), 32'(e.data));
                        chk("txn_ready", 32'(ready), 32'(e.ready));
                        chk("txn_framing_err", 32'(framing_err), 32'(e.fe));
                        chk("txn_overrun", 32'(overrun), 32'(e.ovr));
                    end
                end
                prev_busy = busy;
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] partial;
        int         gap;
        int         r;

        do_reset();
        check_outputs("reset");

        send_frame(8'hA5, 1'b1, 1'b0);
        idle(4, 1'b0);

        send_glitch();
        idle(2, 1'b1);

        send_frame(8'h3C, 1'b0, 1'b0);
        idle(2, 1'b1);
        check_outputs("after_clr");

        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(2, 1'b1);

        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1);
        idle(2, 1'b0);

        // Abort frame 0xF0 just after bit 3, then reset.
        partial = 8'hF0;
        for (int p = 0; p < 80; p++) begin
            period((p < 16) ? 1'b0 : partial[(p - 16) / 16], 1'b0, 3);
        end
        do_reset();
        check_outputs("mid_frame_reset");

        send_frame(8'h5A, 1'b1, 1'b0);
        idle(2, 1'b0);

        for (int n = 0; n < 30; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 10) begin
                send_glitch();
            end else begin
                send_frame(8'($urandom), $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 20);
            end
            gap = int'($urandom_range(0, 3));
            if (gap > 0) idle(gap, $urandom_range(0, 99) < 40);
        end

        idle(3, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        check_outputs("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
